// File: rtl/bus_memory.sv
// Unified program/data memory on the shared 8-bit bus: a two-phase core access
// (address phase, then data phase) plus a side loader port usable when the bus is idle.
module bus_memory #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cmd_valid,
  input  logic              cmd_write,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  output logic              rd_valid,
  output logic              busy,
  output logic              cmd_err,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ack
);

  // state   | meaning
  // IDLE    | accepting an address phase or a loader write
  // RD_DATA | driving the read byte onto the bus
  // WR_DATA | capturing write data from the bus at the closing edge
  typedef enum logic [1:0] {IDLE, RD_DATA, WR_DATA} state_t;

  localparam int DEPTH = 2**ADDR_W;

  // Contents are never reset; the initializer only sets the time-zero image.
  logic [DATA_W-1:0] r_mem [DEPTH] = '{default: (INIT_ZERO ? '0 : 'x)};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_rdata;
  logic              r_cmd_err;
  logic              r_load_ack;
  logic              w_idle;
  logic              w_rd_cmd;
  logic              w_wr_cmd;
  logic              w_load;
  logic              w_wr_commit;
  logic [ADDR_W-1:0] w_bus_addr;

  assign w_idle      = (r_state == IDLE);
  assign w_bus_addr  = bus_in[ADDR_W-1:0];
  assign w_rd_cmd    = w_idle && cmd_valid && !cmd_write;
  assign w_wr_cmd    = w_idle && cmd_valid && cmd_write;
  assign w_load      = w_idle && load_en && !cmd_valid;
  assign w_wr_commit = (r_state == WR_DATA);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_rd_cmd)      w_state_nxt = RD_DATA;
        else if (w_wr_cmd) w_state_nxt = WR_DATA;
      end
      RD_DATA: w_state_nxt = IDLE;
      WR_DATA: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_addr     <= '0;
      r_rdata    <= '0;
      r_cmd_err  <= 1'b0;
      r_load_ack <= 1'b0;
    end else begin
      if (w_rd_cmd || w_wr_cmd) r_addr <= w_bus_addr;
      if (w_rd_cmd)             r_rdata <= r_mem[w_bus_addr];
      r_cmd_err  <= cmd_valid && !w_idle;
      r_load_ack <= w_load;
    end
  end

  // Reset forces r_state to IDLE asynchronously, so an in-flight write never commits.
  always_ff @(posedge CLK) begin
    if (w_wr_commit)  r_mem[r_addr]    <= bus_in;
    else if (w_load)  r_mem[load_addr] <= load_data;
  end

  assign bus_oe   = (r_state == RD_DATA);
  assign rd_valid = (r_state == RD_DATA);
  assign busy     = (r_state != IDLE);
  assign bus_out  = r_rdata;
  assign cmd_err  = r_cmd_err;
  assign load_ack = r_load_ack;

endmodule

// File: tb/tb_bus_memory.sv
// Directed self-checking bench for bus_memory: reads, writes, command collisions,
// loader arbitration, address wrap and reset during a write data phase.
module tb_bus_memory;

  logic       CLK = 1'b0;
  logic       RST;
  logic       cmd_valid;
  logic       cmd_write;
  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic       rd_valid;
  logic       busy;
  logic       cmd_err;
  logic       load_en;
  logic [7:0] load_addr;
  logic [7:0] load_data;
  logic       load_ack;

  int checks   = 0;
  int failures = 0;

  bus_memory #(.DATA_W(8), .ADDR_W(8), .INIT_ZERO(1'b1)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .cmd_valid (cmd_valid),
    .cmd_write (cmd_write),
    .bus_in    (bus_in),
    .bus_out   (bus_out),
    .bus_oe    (bus_oe),
    .rd_valid  (rd_valid),
    .busy      (busy),
    .cmd_err   (cmd_err),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .load_ack  (load_ack)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_idle_outs(input string tag);
    check({tag, ".bus_oe"},   {7'd0, bus_oe},   8'd0);
    check({tag, ".rd_valid"}, {7'd0, rd_valid}, 8'd0);
    check({tag, ".busy"},     {7'd0, busy},     8'd0);
  endtask

  // Issues a READ address phase, checks the data phase, then returns to idle.
  task automatic do_read(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    cmd_valid = 1'b1; cmd_write = 1'b0; bus_in = addr;
    cyc();
    cmd_valid = 1'b0; bus_in = 8'h00;
    check({tag, ".bus_oe"},  {7'd0, bus_oe},   8'd1);
    check({tag, ".rd_valid"},{7'd0, rd_valid}, 8'd1);
    check({tag, ".data"},    bus_out,          exp);
    cyc();
    check({tag, ".oe_off"},  {7'd0, bus_oe},   8'd0);
  endtask

  task automatic do_write(input string tag, input logic [7:0] addr, input logic [7:0] data);
    cmd_valid = 1'b1; cmd_write = 1'b1; bus_in = addr;
    cyc();
    cmd_valid = 1'b0; cmd_write = 1'b0; bus_in = data;
    check({tag, ".busy"},   {7'd0, busy},   8'd1);
    check({tag, ".bus_oe"}, {7'd0, bus_oe}, 8'd0);
    cyc();
    bus_in = 8'h00;
    check({tag, ".done"},   {7'd0, busy},   8'd0);
  endtask

  initial begin
    RST = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; bus_in = 8'h00;
    load_en = 1'b0; load_addr = 8'h00; load_data = 8'h00;
    #1;
    check_idle_outs("rst");
    check("rst.bus_out", bus_out, 8'h00);
    check("rst.cmd_err", {7'd0, cmd_err}, 8'd0);
    check("rst.load_ack", {7'd0, load_ack}, 8'd0);
    cyc(); cyc();
    RST = 1'b1;

    // preload word 0 through the loader
    load_en = 1'b1; load_addr = 8'h00; load_data = 8'h5A;
    cyc();
    load_en = 1'b0;
    check("preload.ack", {7'd0, load_ack}, 8'd1);
    cyc();
    check("preload.ack_clr", {7'd0, load_ack}, 8'd0);

    do_read("rd00", 8'h00, 8'h5A);

    do_write("wr3c", 8'h3C, 8'hA5);
    do_read("rd3c", 8'h3C, 8'hA5);
    do_read("rd3d", 8'h3D, 8'h00);
    do_read("rd3b", 8'h3B, 8'h00);

    // second command during RD_DATA is dropped and flagged
    cmd_valid = 1'b1; cmd_write = 1'b0; bus_in = 8'h10;
    cyc();
    bus_in = 8'h00;
    check("coll.rd_valid", {7'd0, rd_valid}, 8'd1);
    check("coll.data", bus_out, 8'h00);
    check("coll.err_pre", {7'd0, cmd_err}, 8'd0);
    cyc();
    cmd_valid = 1'b0;
    check("coll.err", {7'd0, cmd_err}, 8'd1);
    check_idle_outs("coll.idle");
    cyc();
    check("coll.err_clr", {7'd0, cmd_err}, 8'd0);
    check_idle_outs("coll.dropped");

    // loader loses to a same-cycle core command, then commits
    load_en = 1'b1; load_addr = 8'h20; load_data = 8'h77;
    cmd_valid = 1'b1; cmd_write = 1'b0; bus_in = 8'h20;
    cyc();
    cmd_valid = 1'b0; bus_in = 8'h00;
    check("arb.old", bus_out, 8'h00);
    check("arb.ack0", {7'd0, load_ack}, 8'd0);
    cyc();
    check("arb.ack_dp", {7'd0, load_ack}, 8'd0);
    cyc();
    load_en = 1'b0;
    check("arb.ack1", {7'd0, load_ack}, 8'd1);
    cyc();
    check("arb.ack_clr", {7'd0, load_ack}, 8'd0);
    do_read("arb.rd20", 8'h20, 8'h77);

    do_write("wrff", 8'hFF, 8'h81);
    do_read("rdff", 8'hFF, 8'h81);
    do_read("rd00b", 8'h00, 8'h5A);

    // reset lands inside WR_DATA
    cmd_valid = 1'b1; cmd_write = 1'b1; bus_in = 8'h44;
    cyc();
    cmd_valid = 1'b0; cmd_write = 1'b0; bus_in = 8'hEE;
    check("rstwr.busy", {7'd0, busy}, 8'd1);
    #2;
    RST = 1'b0;
    #1;
    check_idle_outs("rstwr.async");
    check("rstwr.bus_out", bus_out, 8'h00);
    cyc();
    RST = 1'b1; bus_in = 8'h00;
    cyc();
    check_idle_outs("rstwr.after");
    do_read("rstwr.rd44", 8'h44, 8'h00);
    do_read("rstwr.rd3c", 8'h3C, 8'hA5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_memory.md
Name: bus_memory

Overview:
- Unified program/data memory sitting directly downstream of the core's fetch and decode_exec stages on the shared 8-bit bus.
- Accepts a two-phase access: an address phase, then a data phase.
  - Read: returns the addressed byte on the bus one cycle after the address phase. This is what fetch captures into its buffer.
  - Write: captures the data the core drives in the data phase.
- A side load port fills the memory (program image) while the bus is idle.

Parameters:
- DATA_W, 8, bus and memory word width.
- ADDR_W, 8, address width; depth is fixed at 2**ADDR_W (256 words).
- INIT_ZERO, 1, when 1 all words read 0 at time zero (simulation init only; reset never clears contents).

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RST  input  1  asynchronous active-low reset.
- cmd_valid  input  1  address-phase strobe from core.
- cmd_write  input  1  0 = READ, 1 = WRITE; sampled with cmd_valid.
- bus_in  input  DATA_W  shared bus as seen by memory: carries the address in the address phase and the write data in the write data phase.
- bus_out  output  DATA_W  read data driven onto shared bus.
- bus_oe  output  1  1 = memory drives bus_out; the top level tristates the bus when 0.
- rd_valid  output  1  high in the read data-phase cycle.
- busy  output  1  high in any data-phase cycle.
- cmd_err  output  1  one-cycle pulse: cmd_valid arrived during a data phase and was dropped.
- load_en  input  1  loader write request.
- load_addr  input  ADDR_W  loader address.
- load_data  input  DATA_W  loader data.
- load_ack  output  1  one-cycle pulse, the cycle after a load write is committed.

Behaviour:
- State machine: IDLE, RD_DATA, WR_DATA. Registered state; outputs decoded from registered state and registers only (no combinational path from inputs to bus_oe/bus_out).
- Reset (RST low, asynchronous):
  - State returns to IDLE.
  - bus_oe=0, bus_out=0, rd_valid=0, busy=0, cmd_err=0, load_ack=0.
  - Address latch and read register are cleared to 0.
  - Memory contents are untouched.
  - Reset asserted during WR_DATA aborts the write: no word is modified.
- IDLE, cmd_valid=1, cmd_write=0, at posedge:
  - addr_q <= bus_in.
  - rdata_q <= mem[bus_in].
  - Next state is RD_DATA.
- IDLE, cmd_valid=1, cmd_write=1, at posedge: addr_q <= bus_in; next state is WR_DATA.
- RD_DATA cycle:
  - bus_oe=1, bus_out=rdata_q, rd_valid=1, busy=1.
  - The core samples the bus at the closing edge.
  - Next state is IDLE unconditionally.
  - Read latency: data is valid exactly 1 cycle after the address-phase cycle.
- WR_DATA cycle:
  - bus_oe=0, busy=1.
  - At the closing edge, mem[addr_q] <= bus_in.
  - Next state is IDLE.
  - A read of the same address issued in the following IDLE cycle returns the new value.
- cmd_valid=1 during RD_DATA or WR_DATA: the command is ignored, cmd_err=1 in the next cycle for one cycle, and the data phase completes normally. Maximum throughput is one access per 2 cycles.
- Load port: honoured only in IDLE with cmd_valid=0.
  - At the posedge, mem[load_addr] <= load_data; load_ack=1 in the next cycle.
  - If cmd_valid=1 in the same IDLE cycle, the core command wins, no load occurs, and load_ack stays 0. The loader holds load_en until acked.
  - load_en in a data-phase cycle is not committed, and load_ack stays 0.
- Address arithmetic: ADDR_W bits, no bounds check. All 256 addresses are valid. Address 0xFF is a normal word, and the core's PC wrap 0xFF->0x00 needs no special handling.
- bus_oe is never 1 outside RD_DATA; this guarantees no contention with the core driving address or data.

Test Plan:
- Reset then read: RST low 2 cycles, mem[0x00]=0x5A preloaded. cmd_valid=1, cmd_write=0, bus_in=0x00 -> next cycle bus_oe=1, bus_out=0x5A, rd_valid=1, busy=1; the cycle after, bus_oe=0.
- Write then read-back: WRITE addr 0x3C, data phase bus_in=0xA5. Then READ 0x3C -> bus_out=0xA5 in its data phase; no other word changes.
- Command in data phase: READ 0x10, then cmd_valid=1 during RD_DATA -> cmd_err pulses 1 cycle, the first read completes, the second is not performed (next cycle IDLE, bus_oe=0).
- Load arbitration: load_en=1, load_addr=0x20, load_data=0x77 in the same IDLE cycle as a READ 0x20 -> the read returns the old value 0x00 and load_ack=0. With load_en held, the load commits in the next IDLE cycle without cmd_valid, load_ack=1, and a later READ 0x20 returns 0x77.
- Wrap address: WRITE 0xFF data 0x81, READ 0xFF -> 0x81; READ 0x00 unaffected.
- Reset mid-write: WRITE 0x44 address phase, RST low in WR_DATA with bus_in=0xEE -> mem[0x44] unchanged, all outputs 0 immediately (asynchronously), state IDLE after release.
